mat_a_reader: RTL and testbench
===============================

MAT_A_READER -- requirements
Module: mat_a_reader

Interface
REQ-001 SHALL have parameter N, default 2, number of matrix-A rows.
REQ-002 SHALL have parameter P, default 4, number of matrix-A columns; N*P SHALL be ≤ 256.
REQ-003 SHALL have parameter DW, default 32, element width.
REQ-004 SHALL have port clk, input, 1, the single clock; all flops sample on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port wr_done, input, 1, level high once matrix A is fully written to memory.
REQ-007 SHALL have port addrb, output, 8, read address to matrix-A memory port B.
REQ-008 SHALL have port doutb, input, DW, memory read data, valid exactly 1 cycle after addrb is presented.
REQ-009 SHALL have port elem_data, output, DW, streamed element.
REQ-010 SHALL have port elem_row, output, 8, row index of elem_data.
REQ-011 SHALL have port elem_col, output, 8, column index of elem_data.
REQ-012 SHALL have port elem_valid, output, 1, output element valid.
REQ-013 SHALL have port elem_ready, input, 1, consumer accepts element.
REQ-014 SHALL have port rd_done, output, 1, all N*P elements delivered.

Function
REQ-015 SHALL implement states IDLE, STREAM, DONE.
REQ-016 IDLE -> STREAM SHALL occur on the first clk edge where wr_done=1; addrb=0 in IDLE.
REQ-017 In STREAM, a read SHALL issue (addrb advances by 1 next cycle) only when buffered + in-flight elements < 2 and the issued count < N*P.
REQ-018 Addresses SHALL be issued 0..N*P-1 in row-major order, each exactly once; address N*P is never issued.
REQ-019 Data for each issued address SHALL be captured from doutb exactly 1 cycle after issue into a 2-entry FIFO with its row/col tag.
REQ-020 Row/col tags SHALL come from counters: col wraps P-1 -> 0 with row +1; no divider.
REQ-021 elem_valid SHALL equal FIFO non-empty; elem_data/row/col SHALL show the FIFO head and stay stable while elem_valid=1 and elem_ready=0.
REQ-022 A transfer SHALL occur only on a cycle with elem_valid=1 and elem_ready=1; the head pops that edge.
REQ-023 Simultaneous capture and pop SHALL leave occupancy unchanged with no loss or duplication.
REQ-024 With elem_ready held 1, sustained throughput SHALL be 1 element/cycle after a 2-cycle initial latency (wr_done high to first elem_valid).
REQ-025 STREAM -> DONE SHALL occur on the edge where the N*P-th element transfers; rd_done=1 in DONE only.
REQ-026 DONE -> IDLE SHALL occur when wr_done=0; while wr_done stays 1, DONE SHALL hold.
REQ-027 wr_done dropping during STREAM SHALL be ignored; streaming completes.
REQ-028 elem_ready asserted with elem_valid=0 SHALL have no effect.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, addrb=0, FIFO empty, in-flight flag 0, counters 0, elem_valid=0, elem_data=0, elem_row=0, elem_col=0, rd_done=0.
REQ-030 Reset mid-STREAM SHALL discard all buffered and in-flight data; after release, a new pass starts at address 0 when wr_done=1.

Structure
REQ-031 Shared package mat_pkg SHALL hold N, P, DW defaults, address width 8, and the state enumeration.
REQ-032 The 2-entry tagged FIFO SHALL be sub-module elem_fifo2 (data+row+col, push, pop, full, empty, count).

Verification
REQ-033 N=2,P=4, memory[k]=k, elem_ready=1, wr_done rises at cycle 5 -> elements 0..7 on cycles 7..14 with (row,col) (0,0)..(1,3); rd_done=1 from cycle 15.
REQ-034 Same memory, elem_ready toggles 1/0 each cycle -> 8 elements in order, none duplicated, data stable while ready=0, addrb never exceeds 7.
REQ-035 elem_ready=0 for 20 cycles after wr_done -> addrb stops at 2, elem_valid=1 with data 0 held; after ready=1, 0..7 delivered.
REQ-036 Reset pulsed low after 3 transfers -> all outputs 0 immediately; after release with wr_done=1, stream restarts at element 0.
REQ-037 In DONE, wr_done held 1 for 10 cycles -> no new reads; wr_done 0 then 1 -> second full pass 0..7.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-A reader: default dimensions, tag/address
// widths and the reader state encoding.
package mat_pkg;

  localparam int N_DEF  = 2;
  localparam int P_DEF  = 4;
  localparam int DW_DEF = 32;
  localparam int AW     = 8;
  // One bit wider than AW so a full 256-element count fits.
  localparam int CNT_W  = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } readState_t;

endpackage

// File: rtl/elem_fifo2.sv
// Two-entry FIFO holding a data word with its row/column tag; head is shown
// combinationally so the consumer sees it as soon as the FIFO is non-empty.
module elem_fifo2
  import mat_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] pushData,
  input  logic [AW-1:0] pushRow,
  input  logic [AW-1:0] pushCol,
  input  logic          pop,
  output logic [DW-1:0] headData,
  output logic [AW-1:0] headRow,
  output logic [AW-1:0] headCol,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] dataMem [2];
  logic [AW-1:0] rowMem  [2];
  logic [AW-1:0] colMem  [2];
  logic          wrPtr;
  logic          rdPtr;
  logic          pushOk;
  logic          popOk;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign popOk  = pop && !empty;
  assign pushOk = push && (!full || popOk);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        dataMem[i] <= '0;
        rowMem[i]  <= '0;
        colMem[i]  <= '0;
      end
    end else begin
      if (pushOk) begin
        dataMem[wrPtr] <= pushData;
        rowMem[wrPtr]  <= pushRow;
        colMem[wrPtr]  <= pushCol;
        wrPtr          <= ~wrPtr;
      end
      if (popOk) begin
        rdPtr <= ~rdPtr;
      end
      case ({pushOk, popOk})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign headData = dataMem[rdPtr];
  assign headRow  = rowMem[rdPtr];
  assign headCol  = colMem[rdPtr];

endmodule

// File: rtl/mat_a_reader.sv
// Streams matrix A out of a 1-cycle-latency memory in row-major order once it
// has been written, tagging each element with its row/column.
module mat_a_reader
  import mat_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int P  = P_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_done,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] doutb,
  output logic [DW-1:0] elem_data,
  output logic [AW-1:0] elem_row,
  output logic [AW-1:0] elem_col,
  output logic          elem_valid,
  input  logic          elem_ready,
  output logic          rd_done
);

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(N * P);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(N * P - 1);
  localparam logic [AW-1:0]    COL_END = AW'(P - 1);

  readState_t       state;
  readState_t       stateNext;
  logic [CNT_W-1:0] issuedCnt;
  logic [CNT_W-1:0] deliveredCnt;
  logic [AW-1:0]    issueRow;
  logic [AW-1:0]    issueCol;
  logic             inFlight;
  logic [AW-1:0]    inFlightRow;
  logic [AW-1:0]    inFlightCol;
  logic             issue;
  logic             popFire;
  logic             passClear;
  logic             roomForIssue;
  logic [2:0]       slotsUsed;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [1:0]       fifoCount;

  assign popFire   = elem_valid && elem_ready;
  assign passClear = (state == DONE) && !wr_done;

  // Count the element leaving this edge as free space, otherwise the FIFO
  // would stall every other cycle and never reach one element per cycle.
  assign slotsUsed    = {1'b0, fifoCount} + {2'b00, inFlight};
  assign roomForIssue = popFire || (!fifoFull && (slotsUsed < 3'd2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Address 0 is already on addrb in IDLE, so the IDLE->STREAM edge counts as
  // its issue; that is what gives the 2-cycle wr_done-to-valid latency.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_done) begin
          stateNext = STREAM;
          issue     = 1'b1;
        end
      end
      STREAM: begin
        issue = roomForIssue && (issuedCnt < TOTAL_C);
        if (popFire && (deliveredCnt == LAST_C)) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (!wr_done) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // addrb stops on the last address instead of stepping to N*P.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrb        <= '0;
      issuedCnt    <= '0;
      deliveredCnt <= '0;
      issueRow     <= '0;
      issueCol     <= '0;
      inFlight     <= 1'b0;
      inFlightRow  <= '0;
      inFlightCol  <= '0;
    end else if (passClear) begin
      addrb        <= '0;
      issuedCnt    <= '0;
      deliveredCnt <= '0;
      issueRow     <= '0;
      issueCol     <= '0;
      inFlight     <= 1'b0;
    end else begin
      inFlight <= issue;
      if (issue) begin
        inFlightRow <= issueRow;
        inFlightCol <= issueCol;
        issuedCnt   <= issuedCnt + CNT_W'(1);
        if ((issuedCnt + CNT_W'(1)) < TOTAL_C) begin
          addrb <= addrb + AW'(1);
        end
        if (issueCol == COL_END) begin
          issueCol <= '0;
          issueRow <= issueRow + AW'(1);
        end else begin
          issueCol <= issueCol + AW'(1);
        end
      end
      if (popFire) begin
        deliveredCnt <= deliveredCnt + CNT_W'(1);
      end
    end
  end

  elem_fifo2 #(
    .DW(DW)
  ) fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inFlight),
    .pushData (doutb),
    .pushRow  (inFlightRow),
    .pushCol  (inFlightCol),
    .pop      (popFire),
    .headData (elem_data),
    .headRow  (elem_row),
    .headCol  (elem_col),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign elem_valid = !fifoEmpty;
  assign rd_done    = (state == DONE);

endmodule

// File: tb/tb_mat_a_reader.sv
// Scoreboard bench for mat_a_reader: each pass pushes the expected row-major
// elements, and a negedge monitor compares the FIFO head against the queue front.
module tb_mat_a_reader;
  import mat_pkg::*;

  localparam int N  = 2;
  localparam int P  = 4;
  localparam int DW = 32;
  localparam int NP = N * P;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
  } elem_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_done = 1'b0;
  logic          elem_ready = 1'b0;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb = '0;
  logic [DW-1:0] elem_data;
  logic [AW-1:0] elem_row;
  logic [AW-1:0] elem_col;
  logic          elem_valid;
  logic          rd_done;

  logic [DW-1:0] memory [256];
  elem_t         sbQueue [$];
  elem_t         head;
  int            assertCount = 0;
  int            failCount = 0;
  int            xferCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) doutb <= memory[addrb];

  mat_a_reader #(
    .N (N),
    .P (P),
    .DW(DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_done    (wr_done),
    .addrb      (addrb),
    .doutb      (doutb),
    .elem_data  (elem_data),
    .elem_row   (elem_row),
    .elem_col   (elem_col),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .rd_done    (rd_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wrDoneVal, input logic readyVal, input bit newPass);
    if (newPass) begin
      for (int k = 0; k < NP; k++) begin
        sbQueue.push_back('{data: memory[k], row: AW'(k / P), col: AW'(k % P)});
      end
    end
    wr_done    = wrDoneVal;
    elem_ready = readyVal;
  endtask

  task automatic runUntilDone(input int maxCycles, input bit toggleReady);
    int n = 0;
    while (!rd_done && n < maxCycles) begin
      @(posedge clk);
      #1;
      if (toggleReady) elem_ready = ~elem_ready;
      n++;
    end
    checkOutput("done_reached", 32'(rd_done), 32'd1);
    elem_ready = 1'b1;
  endtask

  // Head must match the queue front on every valid cycle, which also proves it
  // holds still while elem_ready is low.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("addrb_bound", 32'(addrb <= AW'(NP - 1)), 32'd1);
      if (elem_valid) begin
        checkOutput("sb_has_entry", 32'(sbQueue.size() != 0), 32'd1);
        if (sbQueue.size() != 0) begin
          head = sbQueue[0];
          checkOutput("elem_data", elem_data, head.data);
          checkOutput("elem_row", 32'(elem_row), 32'(head.row));
          checkOutput("elem_col", 32'(elem_col), 32'(head.col));
          if (elem_ready) begin
            void'(sbQueue.pop_front());
            xferCount++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    for (int k = 0; k < 256; k++) memory[k] = DW'(k);

    // Reset state while reset is held low.
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_addrb", 32'(addrb), 32'd0);
    checkOutput("rst_valid", 32'(elem_valid), 32'd0);
    checkOutput("rst_data", elem_data, 32'd0);
    checkOutput("rst_row", 32'(elem_row), 32'd0);
    checkOutput("rst_col", 32'(elem_col), 32'd0);
    checkOutput("rst_rd_done", 32'(rd_done), 32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("idle_addrb", 32'(addrb), 32'd0);
    checkOutput("idle_valid", 32'(elem_valid), 32'd0);

    // Full-rate pass: valid on cycles +2..+9 after wr_done, rd_done from +10.
    $display("[TB] pass with elem_ready held high");
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput("t1_valid", 32'(elem_valid), 32'(c >= 2 && c <= 9));
      checkOutput("t1_rd_done", 32'(rd_done), 32'(c >= 10));
    end
    checkOutput("t1_sb_empty", 32'(sbQueue.size()), 32'd0);

    // DONE holds while wr_done stays high, then a second pass after re-arm.
    $display("[TB] DONE hold and second pass");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("t5_hold_done", 32'(rd_done), 32'd1);
      checkOutput("t5_hold_valid", 32'(elem_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t5_still_done", 32'(rd_done), 32'd1);
    @(negedge clk);
    checkOutput("t5_idle_rd_done", 32'(rd_done), 32'd0);
    checkOutput("t5_idle_addrb", 32'(addrb), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    runUntilDone(50, 1'b0);
    checkOutput("t5_sb_empty", 32'(sbQueue.size()), 32'd0);

    // elem_ready toggling every cycle.
    $display("[TB] pass with elem_ready toggling");
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    runUntilDone(100, 1'b1);
    checkOutput("t2_sb_empty", 32'(sbQueue.size()), 32'd0);

    // Consumer stalled for 20 cycles: two reads issued, head 0 held.
    $display("[TB] pass with consumer stalled");
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t3_addrb_stall", 32'(addrb), 32'd2);
    checkOutput("t3_valid_stall", 32'(elem_valid), 32'd1);
    checkOutput("t3_data_stall", elem_data, 32'd0);
    elem_ready = 1'b1;
    runUntilDone(50, 1'b0);
    checkOutput("t3_sb_empty", 32'(sbQueue.size()), 32'd0);

    // Reset after three transfers, then a fresh pass from element 0.
    $display("[TB] reset during stream");
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    base = xferCount;
    n = 0;
    while ((xferCount - base) < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checkOutput("t4_three_xfers", 32'(xferCount - base), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t4_rst_addrb", 32'(addrb), 32'd0);
    checkOutput("t4_rst_valid", 32'(elem_valid), 32'd0);
    checkOutput("t4_rst_data", elem_data, 32'd0);
    checkOutput("t4_rst_row", 32'(elem_row), 32'd0);
    checkOutput("t4_rst_col", 32'(elem_col), 32'd0);
    checkOutput("t4_rst_rd_done", 32'(rd_done), 32'd0);
    sbQueue.delete();
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    runUntilDone(50, 1'b0);
    checkOutput("t4_sb_empty", 32'(sbQueue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
